mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port Hack memory (RAM16K-style: combinational read, write on clock edge when load=1) between requester 0 (CPU data port) and requester 1 (screen/DMA scanner). Uses a req/gnt/ack handshake, round-robin priority on ties and a parameterised access hold time. Sits between the requesters and the RAM instance, in front of the register/flip-flop-based memory hierarchy.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr_pick.sv | 14 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port Hack memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick between two requesters; on a tie the
// requester that was not served last wins.
module mem_arbiter_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between a CPU data port (0) and a screen/DMA
// scanner (1) with a req/gnt/ack handshake and a programmable hold time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int HOLD       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  load0,
    input  logic [WIDTH-1:0]      in0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  load1,
    input  logic [WIDTH-1:0]      in1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [WIDTH-1:0]      out,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_load,
    output logic [WIDTH-1:0]      ram_in,
    input  logic [WIDTH-1:0]      ram_out
);

    localparam int              CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    load_q, load_d;
    logic [WIDTH-1:0]        in_q, in_d;
    logic [WIDTH-1:0]        out_q, out_d;
    logic                    pick_valid;
    logic                    pick_winner;

    mem_arbiter_rr_pick u_rr_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        load_d  = load_q;
        in_d    = in_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    addr_d  = pick_winner ? addr1 : addr0;
                    load_d  = pick_winner ? load1 : load0;
                    in_d    = pick_winner ? in1   : in0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // On a write this captures the pre-write contents.
                    out_d   = ram_out;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    logic in_busy;
    logic in_ack;

    // Everything toward the RAM and requesters comes from registered state only.
    assign in_busy  = (state_q == ST_BUSY);
    assign in_ack   = (state_q == ST_ACK);
    assign gnt0     = (in_busy | in_ack) & ~owner_q;
    assign gnt1     = (in_busy | in_ack) &  owner_q;
    assign ack0     = in_ack & ~owner_q;
    assign ack1     = in_ack &  owner_q;
    assign ram_load = in_busy & load_q & (cnt_q == '0);
    assign ram_addr = addr_q;
    assign ram_in   = in_q;
    assign out      = out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed handshake/timing cases, a HOLD=3
// instance, then two randomized requesters checked against a memory model.
module tb_mem_arbiter;

    localparam int W  = 16;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // HOLD=1 instance
    logic          req0, load0, req1, load1;
    logic [AW-1:0] addr0, addr1, ram_addr;
    logic [W-1:0]  in0, in1, dout, ram_in, ram_out;
    logic          gnt0, gnt1, ack0, ack1, ram_load;

    // HOLD=3 instance
    logic          h_req0, h_load0, h_req1, h_load1;
    logic [AW-1:0] h_addr0, h_addr1, h_ram_addr;
    logic [W-1:0]  h_in0, h_in1, h_out, h_ram_in, h_ram_out;
    logic          h_gnt0, h_gnt1, h_ack0, h_ack1, h_ram_load;

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .HOLD(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .load0(load0), .in0(in0),
        .req1(req1), .addr1(addr1), .load1(load1), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .out(dout),
        .ram_addr(ram_addr), .ram_load(ram_load), .ram_in(ram_in), .ram_out(ram_out)
    );

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .HOLD(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0(h_req0), .addr0(h_addr0), .load0(h_load0), .in0(h_in0),
        .req1(h_req1), .addr1(h_addr1), .load1(h_load1), .in1(h_in1),
        .gnt0(h_gnt0), .gnt1(h_gnt1), .ack0(h_ack0), .ack1(h_ack1), .out(h_out),
        .ram_addr(h_ram_addr), .ram_load(h_ram_load), .ram_in(h_ram_in), .ram_out(h_ram_out)
    );

    // RAM16K-style memories: combinational read, write on the clock edge.
    logic [W-1:0]  mem1 [0:(1<<AW)-1];
    logic [W-1:0]  mem3 [0:(1<<AW)-1];
    logic          poke_en, poke_tgt;
    logic [AW-1:0] poke_addr;
    logic [W-1:0]  poke_data;
    int            wr_strobes = 0;

    always @(posedge clk) begin
        if (poke_en && !poke_tgt) mem1[poke_addr] <= poke_data;
        else if (ram_load) begin
            mem1[ram_addr] <= ram_in;
            wr_strobes     <= wr_strobes + 1;
        end
    end
    always @(posedge clk) begin
        if (poke_en && poke_tgt) mem3[poke_addr] <= poke_data;
        else if (h_ram_load) mem3[h_ram_addr] <= h_ram_in;
    end
    assign ram_out   = mem1[ram_addr];
    assign h_ram_out = mem3[h_ram_addr];

    // Reference model: memory contents as seen by the requesters, in issue order.
    logic [W-1:0] ref_mem [int];
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    int checks = 0;
    int errors = 0;
    int exp_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic poke(input bit tgt, input logic [AW-1:0] a, input logic [W-1:0] d);
        poke_tgt = tgt; poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
        if (!tgt) ref_mem[int'(a)] = d;
    endtask

    // Monitor: pops the expected read data whenever an ack appears.
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_onehot", gnt0 & gnt1, 0);
            check("load_needs_gnt", ram_load & ~(gnt0 | gnt1), 0);
            if (ack0) begin
                check("ack0_gnt0", gnt0, 1);
                if (q0.size() == 0) check("ack0_unexpected", ack0, 0);
                else check("out_req0", dout, q0.pop_front());
            end
            if (ack1) begin
                check("ack1_gnt1", gnt1, 1);
                if (q1.size() == 0) check("ack1_unexpected", ack1, 0);
                else check("out_req1", dout, q1.pop_front());
            end
        end
    end

    // Issue one access on the HOLD=1 instance (called at a negedge) and wait
    // for its ack; returns latency in cycles plus per-access observations.
    task automatic do_access(input bit port, input logic [AW-1:0] a, input bit ld,
                             input logic [W-1:0] d, output int lat, output int gcnt,
                             output int lcnt, output logic [AW-1:0] laddr);
        bit got;
        if (port) q1.push_back(ref_mem[int'(a)]);
        else      q0.push_back(ref_mem[int'(a)]);
        if (ld) begin
            ref_mem[int'(a)] = d;
            exp_writes++;
        end
        if (port) begin addr1 = a; load1 = ld; in1 = d; req1 = 1'b1; end
        else      begin addr0 = a; load0 = ld; in0 = d; req0 = 1'b1; end
        lat = 0; gcnt = 0; lcnt = 0; laddr = '0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            gcnt += int'(port ? gnt1 : gnt0);
            if (ram_load) begin lcnt++; laddr = ram_addr; end
            got = port ? ack1 : ack0;
        end
        check(port ? "ack1_arrived" : "ack0_arrived", got, 1);
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic rand_requester(input bit port);
        int lat, gc, lc, idle;
        logic [AW-1:0] la, a;
        for (int i = 0; i < 40; i++) begin
            idle = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            repeat (idle) @(negedge clk);
            a = (port ? 14'h200 : 14'h100) | AW'($urandom_range(0, 15));
            do_access(port, a, 1'($urandom_range(0, 1)), W'($urandom), lat, gc, lc, la);
            check(port ? "req1_wait_bound" : "req0_wait_bound", (lat <= 6), 1);
        end
    endtask

    // HOLD=3 access on the second instance, port 0 only.
    task automatic h_access(input bit ld, input logic [AW-1:0] a, input logic [W-1:0] d,
                            input logic [W-1:0] exp_out, input string tag);
        int n, busy_cycles, lcnt, lpos;
        bit got;
        h_addr0 = a; h_load0 = ld; h_in0 = d; h_req0 = 1'b1;
        n = 0; busy_cycles = 0; lcnt = 0; lpos = 0; got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (h_ram_load) begin lcnt++; lpos = n; end
            if (h_gnt0 && !h_ack0 && h_ram_addr == a) busy_cycles++;
            if (h_ack0) begin
                got = 1'b1;
                check({tag, "_out"}, h_out, exp_out);
            end
        end
        h_req0 = 1'b0;
        check({tag, "_ack_seen"}, got, 1);
        check({tag, "_latency"}, n, 4);
        check({tag, "_addr_cycles"}, busy_cycles, 3);
        check({tag, "_load_count"}, lcnt, ld ? 1 : 0);
        if (ld) check({tag, "_load_cycle"}, lpos, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, gc, lc, n, k, c0, c1;
        logic [AW-1:0] la;
        bit order [4];
        int tack [4];
        bit got;

        reset = 1'b1;
        {req0, load0, req1, load1, h_req0, h_load0, h_req1, h_load1} = '0;
        {addr0, addr1, h_addr0, h_addr1} = '0;
        {in0, in1, h_in0, h_in1} = '0;
        poke_en = 1'b0; poke_tgt = 1'b0; poke_addr = '0; poke_data = '0;

        poke(0, 14'd3, 16'h0000);
        poke(0, 14'd2, 16'h0202);
        poke(0, 14'd4, 16'h0404);
        poke(0, 14'd5, 16'h5555);
        poke(0, 14'd7, 16'hBEEF);
        poke(1, 14'd9, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            poke(0, AW'(14'h100 + i), W'(i * 3));
            poke(0, AW'(14'h200 + i), W'(16'h8000 + i));
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_gnt_ack", {gnt0, gnt1, ack0, ack1}, 0);
        check("rst_ram_load", ram_load, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_out", dout, 0);

        // Single write from requester 0.
        do_access(0, 14'd3, 1'b1, 16'h1234, lat, gc, lc, la);
        check("wr_latency", lat, 2);
        check("wr_gnt_cycles", gc, 2);
        check("wr_load_pulses", lc, 1);
        check("wr_load_addr", la, 3);
        @(negedge clk);
        check("wr_mem3", mem1[3], 16'h1234);

        // Single read from requester 1.
        do_access(1, 14'd7, 1'b0, 16'h0000, lat, gc, lc, la);
        check("rd_latency", lat, 2);
        check("rd_gnt_cycles", gc, 2);
        check("rd_no_load", lc, 0);
        @(negedge clk);
        check("rd_out_held", dout, 16'hBEEF);

        // Reset in the middle of a write.
        addr0 = 14'd5; load0 = 1'b1; in0 = 16'hDEAD; req0 = 1'b1;
        @(negedge clk);
        check("midbusy_load_before", ram_load, 1);
        reset = 1'b1;
        #1;
        check("midbusy_load_drop", ram_load, 0);
        check("midbusy_gnt_ack", {gnt0, gnt1, ack0, ack1}, 0);
        check("midbusy_out", dout, 0);
        req0 = 1'b0; load0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midbusy_mem5", mem1[5], 16'h5555);

        // Simultaneous requests straight after reset, both held for two accesses.
        q0.push_back(ref_mem[3]); q0.push_back(ref_mem[3]);
        q1.push_back(ref_mem[7]); q1.push_back(ref_mem[7]);
        addr0 = 14'd3; load0 = 1'b0; req0 = 1'b1;
        addr1 = 14'd7; load1 = 1'b0; req1 = 1'b1;
        n = 0; k = 0; c0 = 0; c1 = 0;
        while (n < 30 && k < 4) begin
            @(negedge clk);
            n++;
            if (ack0 && k < 4) begin
                order[k] = 1'b0; tack[k] = n; k++; c0++;
                if (c0 == 2) req0 = 1'b0;
            end
            if (ack1 && k < 4) begin
                order[k] = 1'b1; tack[k] = n; k++; c1++;
                if (c1 == 2) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie_ack_count", k, 4);
        for (int i = 0; i < 4; i++) check($sformatf("tie_order_%0d", i), order[i], i % 2);
        for (int i = 1; i < 4; i++) check($sformatf("tie_gap_%0d", i), tack[i] - tack[i-1], 3);
        @(negedge clk);

        // Inputs changed after grant must not affect the access.
        q0.push_back(ref_mem[2]);
        ref_mem[2] = 16'hA5A5;
        exp_writes++;
        addr0 = 14'd2; load0 = 1'b1; in0 = 16'hA5A5; req0 = 1'b1;
        @(posedge clk);
        #1 addr0 = 14'd4; in0 = 16'hFFFF;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (ram_load) check("chg_load_addr", ram_addr, 2);
            got = ack0;
        end
        check("chg_ack_arrived", got, 1);
        req0 = 1'b0; load0 = 1'b0;
        @(negedge clk);
        check("chg_mem2", mem1[2], 16'hA5A5);
        check("chg_mem4", mem1[4], 16'h0404);

        // HOLD=3: write then read back.
        h_access(1'b1, 14'd9, 16'h00FF, 16'h0000, "h3_wr");
        check("h3_mem9", mem3[9], 16'h00FF);
        @(negedge clk);
        h_access(1'b0, 14'd9, 16'h0000, 16'h00FF, "h3_rd");

        // Randomized traffic from both requesters on disjoint address ranges.
        @(negedge clk);
        fork
            rand_requester(0);
            rand_requester(1);
        join
        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("write_strobes", wr_strobes, exp_writes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
